// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit: bus width,
// stall vector encodings, stall bit indices and the redirect-pending state.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W   = 32;
    localparam int unsigned STALL_W = 6;

    // Bit positions within the stall vector
    localparam int unsigned SB_PC  = 0;
    localparam int unsigned SB_IF  = 1;
    localparam int unsigned SB_ID  = 2;
    localparam int unsigned SB_EX  = 3;
    localparam int unsigned SB_MEM = 4;
    localparam int unsigned SB_WB  = 5;

    // Only monotonic vectors are legal; WB is never held
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        PEND_IDLE,
        PEND_HELD
    } pend_state_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous reset, synchronous clear and enable.
module pipe_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, flush redirect with deferral behind
// memory waits, stall-cycle counter and memory-wait watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               flush_req,
    input  logic [REG_W-1:0]   flush_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [REG_W-1:0]   new_pc,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               mem_timeout
);

    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);

    pend_state_t      state;
    pend_state_t      state_nxt;
    logic [REG_W-1:0] pend_pc;
    logic [15:0]      mem_wait_cnt;
    logic             issue_pend;
    logic             issue_new;
    logic             defer;

    assign issue_pend = !rst && (state == PEND_HELD) && !stallreq_mem;
    assign issue_new  = !rst && (state == PEND_IDLE) && flush_req && !stallreq_mem;
    assign defer      = !rst && (state == PEND_IDLE) && flush_req && stallreq_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PEND_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // flush_req is ignored entirely while a redirect is held
    always_comb begin
        state_nxt = state;
        case (state)
            PEND_IDLE: if (defer)      state_nxt = PEND_HELD;
            PEND_HELD: if (issue_pend) state_nxt = PEND_IDLE;
            default:                   state_nxt = PEND_IDLE;
        endcase
    end

    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = '0;
        if (rst) begin
            stall = STALL_NONE;
        end else if (issue_pend) begin
            flush  = 1'b1;
            new_pc = pend_pc;
        end else if (issue_new) begin
            flush  = 1'b1;
            new_pc = flush_pc;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (stallreq_ex) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end else if (stallreq_if) begin
            stall = STALL_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_pc <= '0;
        end else if (defer) begin
            pend_pc <= flush_pc;
        end
    end

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (stall != STALL_NONE),
        .count (stall_cycles)
    );

    pipe_sat_cnt #(.W(16)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!stallreq_mem),
        .en    (stallreq_mem),
        .count (mem_wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (stallreq_mem && (mem_wait_cnt == WAIT_LIMIT)) begin
            mem_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit for the 5-stage RISC-V core.
- Produces the shared stall[5:0] vector and the flush/new_pc redirect consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates per-stage stall requests, defers flushes that collide with an in-flight memory access, and keeps a stall-cycle counter and a memory-wait watchdog flag.

Parameters:
- CNT_W, 32, width of the stall_cycles performance counter.
- MEM_TIMEOUT, 1024, consecutive stallreq_mem cycles that set mem_timeout (must be ≥1 and < 2^16).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  instruction fetch wait
- stallreq_id  in  1  load-use hazard from decode
- stallreq_ex  in  1  multi-cycle EX op busy (mul/div)
- stallreq_mem  in  1  data memory wait
- flush_req  in  1  single-cycle redirect request (exception/trap return)
- flush_pc  in  `RegBus  redirect target, valid with flush_req
- stall  out  6  stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- flush  out  1  kill all in-flight instructions this cycle
- new_pc  out  `RegBus  redirect target, valid when flush=1, else 0
- stall_cycles  out  CNT_W  saturating count of cycles with stall≠0
- mem_timeout  out  1  sticky watchdog flag

Behaviour:
- stall, flush and new_pc are combinational from the inputs and the registered state, so consumers act at the same clock edge. stall_cycles and mem_timeout are registered.
- Stall encoding contract: a stage register holds when stall[k]=1. It inserts a bubble when stall[k]=1 and stall[k+1]=0. The vector is always monotonic. Legal values are 000000, 000011 (IF), 000111 (ID), 001111 (EX), 011111 (MEM). No other value is ever driven, including 111111.
- Priority (highest first): rst > issuing flush > stallreq_mem > stallreq_ex > stallreq_id > stallreq_if.
- rst asserted: stall=0, flush=0, new_pc=0. pend, pend_pc, mem_wait_cnt, stall_cycles and mem_timeout are cleared at the edge.
- Registered state: pend (1 bit), pend_pc (`RegBus), mem_wait_cnt (16 bits, saturating).
- Flush, normal case: flush_req=1 and stallreq_mem=0 with pend=0.
  - flush=1, new_pc=flush_pc, stall=000000.
  - IF/ID/EX stall requests are ignored that cycle.
- Flush, deferred case: flush_req=1 and stallreq_mem=1 with pend=0.
  - pend←1 and pend_pc←flush_pc at the edge.
  - flush=0 and stall=011111 that cycle.
- Pending issue: the first cycle with pend=1 and stallreq_mem=0 gives flush=1, new_pc=pend_pc, stall=000000. pend←0 at that edge.
- flush_req arriving while pend=1 is dropped. The older pending redirect wins.
- flush_req and pend issue in the same cycle: the pend issue wins and flush_req is dropped.
- While pend=1 and stallreq_mem=0, flush_req is still dropped.
- mem_wait_cnt:
  - increments each cycle stallreq_mem=1 and saturates;
  - cleared by any cycle with stallreq_mem=0.
  - When stallreq_mem=1 and mem_wait_cnt = MEM_TIMEOUT-1, mem_timeout←1 at that edge.
  - mem_timeout stays 1 until rst.
  - The watchdog does not alter stall; it only reports.
- stall_cycles increments by 1 at each edge where stall≠000000. It holds at 2^CNT_W-1.
- Flush cycles are not counted, because stall=0 in them.

Decomposition:
- defines.v gets the stall encodings `StallNone, `StallIF, `StallID, `StallEX and `StallMEM, plus stall bit index names.
- `RegBus in defines.v already sets the pc width.
- One sub-module, pipe_sat_cnt: a parameterised-width saturating counter with clear and enable. It is instantiated for stall_cycles and mem_wait_cnt.

Test Plan:
- Reset: hold rst with all requests=1 and flush_req=1 → stall=000000, flush=0, new_pc=0. After release with no requests, stall_cycles=0 and mem_timeout=0.
- Priority:
  - stallreq_if=1 alone → 000011.
  - stallreq_id and stallreq_if → 000111.
  - add stallreq_ex → 001111.
  - add stallreq_mem → 011111.
  - stall_cycles=4 after 4 such cycles.
- Immediate flush: flush_req=1, flush_pc=0x00000080, stallreq_id=1, stallreq_mem=0 → same cycle flush=1, new_pc=0x80, stall=000000.
- Deferred flush:
  - stallreq_mem=1 for 3 cycles; flush_req pulse with 0x100 in cycle 1, and a second pulse with 0x200 in cycle 2.
  - → flush=0 and stall=011111 during cycles 1–3.
  - Cycle 4 (mem=0) gives flush=1, new_pc=0x100. The 0x200 request is dropped.
- Watchdog with MEM_TIMEOUT=8: stallreq_mem=1 for 7 cycles, then 0, then 1 for 8 cycles.
  - mem_timeout stays 0 through the first burst.
  - mem_timeout rises after the 8th cycle of the second burst and stays 1 until rst.
- Saturation with CNT_W=3: 10 consecutive stall cycles → stall_cycles stops at 7.
